// File: rtl/periferico_pkg.sv
// Shared types and defaults for the periferico_rx_hs peripheral handshake receiver.
package periferico_pkg;
  localparam int DATA_W_DEF = 2;
  localparam int DEPTH_DEF  = 4;

  typedef enum logic [1:0] {
    RESYNC = 2'd0,
    IDLE   = 2'd1,
    ACK    = 2'd2
  } state_e;
endpackage

// File: rtl/periferico_rx_hs_if.sv
// Send/ack handshake from the CPU plus the valid/ready drain port toward the local sink.
interface periferico_rx_hs_if
  import periferico_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) ();
  logic              send;
  logic [DATA_W-1:0] dado;
  logic              ack;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output send, dado, out_ready,
    input  ack, out_data, out_valid
  );

  modport slave (
    input  send, dado, out_ready,
    output ack, out_data, out_valid
  );
endinterface

// File: rtl/periferico_rx_hs_fifo.sv
// hs_fifo: small power-of-two FIFO with registered count; head reads as 0 when empty.
module hs_fifo #(
  parameter int DATA_W = 2,
  parameter int DEPTH  = 4
) (
  input  logic                       clk1,
  input  logic                       rst1,
  input  logic                       push,
  input  logic                       pop,
  input  logic [DATA_W-1:0]          wdata,
  output logic [DATA_W-1:0]          rdata,
  output logic                       valid,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic              empty;
  logic              do_push;
  logic              do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign valid   = !empty;
  assign rdata   = empty ? '0 : mem[rd_ptr];

  // Contents are not reset; count==0 already masks stale entries.
  always_ff @(posedge clk1) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk1) begin
    if (!rst1) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/periferico_rx_hs.sv
// Peripheral receiver for the CPU 4-phase send/ack handshake; PERIPH_SYNC_EN adds a 2-flop send synchroniser.
//  state  | meaning
//  RESYNC | ack=0, waiting for send low so a stale request is not re-accepted
//  IDLE   | ack=0, capture dado on send when FIFO has room
//  ACK    | ack=1, waiting for send to drop
module periferico_rx_hs
  import periferico_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic                   clk1,
  input  logic                   rst1,
  periferico_rx_hs_if.slave      bus,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   overflow
);
  localparam logic [1:0] S_RESYNC = RESYNC;
  localparam logic [1:0] S_IDLE   = IDLE;
  localparam logic [1:0] S_ACK    = ACK;

  logic [1:0] state;
  logic [1:0] state_nx;
  logic       send_s;
  logic       full;
  logic       push;
  logic       pop;

`ifdef PERIPH_SYNC_EN
  logic [1:0] sync_q;
  always_ff @(posedge clk1) begin
    if (!rst1) sync_q <= '0;
    else       sync_q <= {sync_q[0], bus.send};
  end
  assign send_s = sync_q[1];
`else
  assign send_s = bus.send;
`endif

  assign push    = (state == S_IDLE) && send_s && !full;
  assign pop     = bus.out_valid && bus.out_ready;
  assign bus.ack = (state == S_ACK);

  always_comb begin
    state_nx = state;
    case (state)
      S_RESYNC: if (!send_s) state_nx = S_IDLE;
      S_IDLE:   if (push)    state_nx = S_ACK;
      S_ACK:    if (!send_s) state_nx = S_IDLE;
      default:               state_nx = S_RESYNC;
    endcase
  end

  always_ff @(posedge clk1) begin
    if (!rst1) begin
      state    <= S_RESYNC;
      overflow <= 1'b0;
    end else begin
      state <= state_nx;
      if ((state == S_IDLE) && send_s && full) overflow <= 1'b1;
    end
  end

  hs_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
    .clk1  (clk1),
    .rst1  (rst1),
    .push  (push),
    .pop   (pop),
    .wdata (bus.dado),
    .rdata (bus.out_data),
    .valid (bus.out_valid),
    .full  (full),
    .count (fifo_count)
  );
endmodule

// File: tb/tb_periferico_rx_hs.sv
// Directed scoreboard bench for periferico_rx_hs; latency expectations follow PERIPH_SYNC_EN.
module tb_periferico_rx_hs;
  import periferico_pkg::*;

  localparam int DW = 2;
  localparam int DP = 4;
`ifdef PERIPH_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic       clk1 = 1'b0;
  logic       rst1 = 1'b0;
  logic [2:0] fifo_count;
  logic       overflow;

  always #5 clk1 = ~clk1;

  periferico_rx_hs_if #(.DATA_W(DW)) bus ();

  periferico_rx_hs #(.DATA_W(DW), .DEPTH(DP)) dut (
    .clk1       (clk1),
    .rst1       (rst1),
    .bus        (bus),
    .fifo_count (fifo_count),
    .overflow   (overflow)
  );

  int          tests = 0;
  int          fails = 0;
  logic [1:0]  exp_q [$];

  task automatic tick();
    @(posedge clk1);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_hs(input logic [1:0] d, input string tag);
    int n;
    bus.dado = d;
    bus.send = 1'b1;
    n = 0;
    while (bus.ack !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check({tag, " ack rise cycles"}, n, LAT);
    exp_q.push_back(d);
    bus.send = 1'b0;
    n = 0;
    while (bus.ack !== 1'b0 && n < 20) begin
      tick();
      n++;
    end
    check({tag, " ack fall cycles"}, n, LAT);
    check({tag, " count"}, fifo_count, exp_q.size());
  endtask

  task automatic pop_one(input string tag);
    logic [1:0] e;
    e = exp_q.pop_front();
    check({tag, " valid"}, bus.out_valid, 1'b1);
    check({tag, " data"}, bus.out_data, e);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check({tag, " count after pop"}, fifo_count, exp_q.size());
  endtask

  task automatic check_empty(input string tag);
    check({tag, " empty count"}, fifo_count, 0);
    check({tag, " empty valid"}, bus.out_valid, 1'b0);
    check({tag, " empty data"}, bus.out_data, 2'b00);
  endtask

  initial begin
    bus.send      = 1'b0;
    bus.dado      = '0;
    bus.out_ready = 1'b0;
    rst1          = 1'b0;
    repeat (3) tick();
    check("reset ack", bus.ack, 1'b0);
    check("reset overflow", overflow, 1'b0);
    check_empty("reset");
    rst1 = 1'b1;
    repeat (2) tick();

    // 1: single transfer
    do_hs(2'b10, "t1");
    check("t1 valid", bus.out_valid, 1'b1);
    check("t1 data", bus.out_data, 2'b10);
    pop_one("t1 pop");
    check_empty("t1");

    // 2: fill then backpressure
    for (int i = 0; i < 4; i++) do_hs(2'(i), "t2 fill");
    check("t2 full count", fifo_count, 4);
    bus.dado = 2'b10;
    bus.send = 1'b1;
    repeat (LAT + 4) tick();
    check("t2 ack withheld", bus.ack, 1'b0);
    check("t2 overflow", overflow, 1'b1);
    check("t2 count held", fifo_count, 4);
    pop_one("t2 pop head");
    check("t2 no push on pop edge", bus.ack, 1'b0);
    tick();
    check("t2 fifth accepted", bus.ack, 1'b1);
    exp_q.push_back(2'b10);
    check("t2 count refilled", fifo_count, exp_q.size());
    bus.send = 1'b0;
    repeat (LAT) tick();
    check("t2 ack fall", bus.ack, 1'b0);
    while (exp_q.size() > 0) pop_one("t2 drain");
    check_empty("t2");
    check("t2 overflow sticky", overflow, 1'b1);

    // 3: interleaved pushes and pops across pointer wrap
    for (int i = 0; i < 6; i++) begin
      do_hs(2'(i), "t3 push");
      if (i % 2 == 1) begin
        pop_one("t3 pop");
        pop_one("t3 pop");
      end
    end
    check_empty("t3");

    // 4: simultaneous push and pop at count 2
    do_hs(2'b01, "t4 pre");
    do_hs(2'b10, "t4 pre");
    bus.dado = 2'b11;
    bus.send = 1'b1;
    repeat (LAT - 1) tick();
    check("t4 head before", bus.out_data, exp_q[0]);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    void'(exp_q.pop_front());
    exp_q.push_back(2'b11);
    check("t4 count stays", fifo_count, 2);
    check("t4 ack", bus.ack, 1'b1);
    check("t4 head advanced", bus.out_data, exp_q[0]);
    bus.send = 1'b0;
    repeat (LAT) tick();
    check("t4 ack fall", bus.ack, 1'b0);
    while (exp_q.size() > 0) pop_one("t4 drain");

    // 5: reset while in ACK with send still high
    bus.dado = 2'b01;
    bus.send = 1'b1;
    repeat (LAT) tick();
    check("t5 in ack", bus.ack, 1'b1);
    rst1 = 1'b0;
    tick();
    rst1 = 1'b1;
    exp_q.delete();
    check("t5 reset ack", bus.ack, 1'b0);
    check("t5 reset overflow", overflow, 1'b0);
    check_empty("t5 reset");
    repeat (6) tick();
    check("t5 no recapture ack", bus.ack, 1'b0);
    check("t5 no recapture count", fifo_count, 0);
    bus.send = 1'b0;
    repeat (LAT + 1) tick();
    do_hs(2'b11, "t5 new");
    pop_one("t5 pop");

    // 6: send already high as reset releases
    bus.dado = 2'b10;
    bus.send = 1'b1;
    rst1 = 1'b0;
    tick();
    rst1 = 1'b1;
    repeat (6) tick();
    check("t6 stale ack", bus.ack, 1'b0);
    check("t6 stale count", fifo_count, 0);
    bus.send = 1'b0;
    repeat (LAT + 1) tick();
    do_hs(2'b01, "t6 new");
    pop_one("t6 pop");
    check_empty("t6");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
